// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the decimal telemetry formatter.
package uart_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_CR   = 8'h0D;

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    FIND_MSD,
    LOAD,
    WAIT
  } fmt_state_t;

  typedef enum logic [1:0] {
    PH_DIGIT,
    PH_LF,
    PH_CR
  } fmt_phase_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, DATA_WIDTH cycles per
// conversion, single-cycle done pulse with the result held until the next start.
module bin2bcd_seq
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic [DATA_WIDTH-1:0]   bin_i,
  output logic                    done_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d, adj;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  run_q, run_d;
  logic                  done_q, done_d;

  // Add-3 on every nibble >= 5, then shift the next binary bit into BCD bit 0
  always_comb begin
    adj     = bcd_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    done_d  = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    if (start_i) begin
      shift_d = bin_i;
      bcd_d   = '0;
      cnt_d   = CNT_W'(DATA_WIDTH);
      run_d   = 1'b1;
    end else if (run_q) begin
      bcd_d   = (adj << 1) | BCD_W'(shift_q[DATA_WIDTH-1]);
      shift_d = shift_q << 1;
      cnt_d   = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      done_q  <= done_d;
    end
  end

  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/uart_num_formatter.sv
// Prints an unsigned sample as decimal ASCII (leading zeros suppressed, optional
// LF/CR) one byte at a time over the uart_tx start/din/done handshake.
module uart_num_formatter
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_DIGITS = 5,
  parameter bit          APPEND_EOL = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic                  value_valid,
  output logic                  value_ready,
  output logic                  busy,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_done
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  fmt_state_t                   state_q, state_d;
  fmt_phase_t                   phase_q, phase_d;
  logic [IDX_W-1:0]             idx_q, idx_d, idx_prev, msd;
  logic                         tx_start_q, tx_start_d;
  logic [7:0]                   tx_data_q, tx_data_d;
  logic                         ready_q, ready_d;
  logic                         busy_q, busy_d;
  logic                         conv_start;
  logic                         conv_done;
  logic [4*NUM_DIGITS-1:0]      bcd;
  logic [NUM_DIGITS-1:0][3:0]   digits;

  assign conv_start = value_valid && ready_q;
  assign digits     = bcd;
  assign idx_prev   = idx_q - IDX_W'(1);

  bin2bcd_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .start_i (conv_start),
    .bin_i   (value),
    .done_o  (conv_done),
    .bcd_o   (bcd)
  );

  // Highest nonzero digit; stays 0 for an all-zero result so "0" is printed
  always_comb begin
    msd = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (digits[i] != 4'd0) msd = IDX_W'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      IDLE:     if (value_valid) state_d = CONVERT;
      CONVERT:  if (conv_done) state_d = FIND_MSD;
      FIND_MSD: begin
        idx_d      = msd;
        phase_d    = PH_DIGIT;
        tx_data_d  = ASCII_ZERO + {4'h0, digits[msd]};
        tx_start_d = 1'b1;
        state_d    = LOAD;
      end
      LOAD:     state_d = WAIT;
      WAIT: begin
        if (tx_done) begin
          state_d    = LOAD;
          tx_start_d = 1'b1;
          if (phase_q == PH_DIGIT && idx_q != '0) begin
            idx_d     = idx_prev;
            tx_data_d = ASCII_ZERO + {4'h0, digits[idx_prev]};
          end else if (phase_q == PH_DIGIT && APPEND_EOL) begin
            phase_d   = PH_LF;
            tx_data_d = ASCII_LF;
          end else if (phase_q == PH_LF) begin
            phase_d   = PH_CR;
            tx_data_d = ASCII_CR;
          end else begin
            state_d    = IDLE;
            tx_start_d = 1'b0;
            tx_data_d  = 8'h00;
          end
        end
      end
      default:  state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = !ready_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      phase_q    <= PH_DIGIT;
      idx_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign value_ready = ready_q;
  assign busy        = busy_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;

endmodule

// File: tb/tb_uart_num_formatter.sv
// Directed bench: default formatter driven by a uart_tx responder model, plus a
// second instance without EOL bytes driven by hand.
module tb_uart_num_formatter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic        value_valid = 1'b0;
  logic        value_ready, busy, tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        model_done = 1'b0;
  logic        spur_done = 1'b0;

  logic [15:0] value2 = '0;
  logic        value_valid2 = 1'b0;
  logic        value_ready2, busy2, tx_start2;
  logic [7:0]  tx_data2;
  logic        tx_done2 = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int edges = 0;
  int starts = 0;
  int starts2 = 0;
  int unstable = 0;
  int model_cnt = 0;
  logic [7:0] held = 8'h00;
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  assign tx_done = model_done | spur_done;

  uart_num_formatter dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .busy        (busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done)
  );

  uart_num_formatter #(.APPEND_EOL(1'b0)) dut2 (
    .clk         (clk),
    .reset       (reset),
    .value       (value2),
    .value_valid (value_valid2),
    .value_ready (value_ready2),
    .busy        (busy2),
    .tx_start    (tx_start2),
    .tx_data     (tx_data2),
    .tx_done     (tx_done2)
  );

  always @(posedge clk) edges <= edges + 1;
  always @(posedge clk) if (tx_start2) starts2 <= starts2 + 1;

  // uart_tx stand-in: capture each started byte, answer with done ~10 cycles later
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (tx_start) begin
      got_q.push_back(tx_data);
      held      <= tx_data;
      model_cnt <= 10;
      starts    <= starts + 1;
    end else begin
      if ((model_cnt > 0 || model_done) && tx_data !== held) unstable <= unstable + 1;
      if (model_cnt > 0) begin
        model_cnt <= model_cnt - 1;
        if (model_cnt == 1) model_done <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] v, output int acc);
    int g = 0;
    while (!value_ready && g < 3000) begin @(negedge clk); g++; end
    check("send_ready", 32'(value_ready), 32'd1);
    value = v;
    value_valid = 1'b1;
    acc = edges + 1;
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int acc, input logic [7:0] first);
    int g = 0;
    while (!tx_start && g < 200) begin @(negedge clk); g++; end
    check({tag, "_latency"}, 32'(edges - acc), 32'd18);
    check({tag, "_first_byte"}, 32'(tx_data), 32'(first));
  endtask

  // Last done of a sample: ready must still be low, and high one cycle later
  task automatic wait_finish(input string tag, input int nbytes);
    int g = 0;
    while (!(got_q.size() == nbytes && tx_done) && g < 3000) begin @(negedge clk); g++; end
    check({tag, "_ready_at_done"}, 32'(value_ready), 32'd0);
    @(negedge clk);
    check({tag, "_ready_after"}, 32'(value_ready), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_data_cleared"}, 32'(tx_data), 32'h00);
  endtask

  task automatic check_bytes(input string tag, input logic [63:0] exp, input int n);
    logic [63:0] e;
    e = exp;
    check({tag, "_count"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size(); i++)
      check({tag, "_byte"}, 32'(got_q[i]), 32'(e[8*(n-1-i) +: 8]));
    got_q.delete();
  endtask

  initial begin
    int acc;
    int base;
    int g;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(value_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_ready2", 32'(value_ready2), 32'd1);

    // Stray done while idle
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_spur_ready", 32'(value_ready), 32'd1);
    check("idle_spur_starts", 32'(starts), 32'd0);

    base = starts;
    send(16'd1234, acc);
    wait_start("v1234", acc, 8'h31);
    wait_finish("v1234", 6);
    check("v1234_pulses", 32'(starts - base), 32'd6);
    check_bytes("v1234", 64'h31_32_33_34_0A_0D, 6);

    send(16'd0, acc);
    wait_start("v0", acc, 8'h30);
    wait_finish("v0", 3);
    check_bytes("v0", 64'h30_0A_0D, 3);

    send(16'd65535, acc);
    wait_start("v65535", acc, 8'h36);
    wait_finish("v65535", 7);
    check_bytes("v65535", 64'h36_35_35_33_35_0A_0D, 7);
    check("stable_data", 32'(unstable), 32'd0);

    // Stray done in the middle of conversion
    send(16'd305, acc);
    repeat (5) @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    check("conv_spur_busy", 32'(busy), 32'd1);
    check("conv_spur_start", 32'(tx_start), 32'd0);
    wait_start("v305", acc, 8'h33);
    wait_finish("v305", 5);
    check_bytes("v305", 64'h33_30_35_0A_0D, 5);

    // value_valid held through busy: 99 must wait for the next ready cycle
    value = 16'd42;
    value_valid = 1'b1;
    @(negedge clk);
    value = 16'd99;
    g = 0;
    while (!value_ready && g < 3000) begin @(negedge clk); g++; end
    check("hold_first_only", 32'(got_q.size()), 32'd4);
    @(negedge clk);
    value_valid = 1'b0;
    wait_finish("hold", 8);
    check_bytes("hold", 64'h34_32_0A_0D_39_39_0A_0D, 8);

    // No-EOL instance: a single digit byte
    value2 = 16'd7;
    value_valid2 = 1'b1;
    acc = edges + 1;
    @(negedge clk);
    value_valid2 = 1'b0;
    g = 0;
    while (!tx_start2 && g < 200) begin @(negedge clk); g++; end
    check("noeol_latency", 32'(edges - acc), 32'd18);
    check("noeol_byte", 32'(tx_data2), 32'h37);
    repeat (3) @(negedge clk);
    tx_done2 = 1'b1;
    @(negedge clk);
    tx_done2 = 1'b0;
    check("noeol_ready", 32'(value_ready2), 32'd1);
    check("noeol_data_cleared", 32'(tx_data2), 32'h00);
    repeat (40) @(negedge clk);
    check("noeol_pulses", 32'(starts2), 32'd1);

    // Reset while waiting on the second digit of 500; a sample offered with reset is dropped
    send(16'd500, acc);
    g = 0;
    while (got_q.size() < 2 && g < 500) begin @(negedge clk); g++; end
    repeat (2) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    value = 16'd77;
    value_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    value_valid = 1'b0;
    check("mid_rst_ready", 32'(value_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_start", 32'(tx_start), 32'd0);
    check("mid_rst_data", 32'(tx_data), 32'h00);
    repeat (20) @(negedge clk);
    check("late_done_ready", 32'(value_ready), 32'd1);
    check_bytes("v500_partial", 64'h35_30, 2);

    send(16'd8, acc);
    wait_start("v8", acc, 8'h38);
    wait_finish("v8", 3);
    check_bytes("v8", 64'h38_0A_0D, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_num_formatter.md
Name: uart_num_formatter

Overview:
Upstream feeder for uart_tx. Accepts a binary sample, such as a distance or PID error magnitude, and converts it to unsigned decimal ASCII with leading zeros suppressed. Then streams the digits, followed by LF and CR, one byte at a time over the uart_tx start/din/done handshake. It replaces fixed-string message sources when telemetry values must be printed.

Parameters:
DATA_WIDTH, 16, bit width of the input value.
NUM_DIGITS, 5, number of BCD digits; must satisfy 10^NUM_DIGITS > 2^DATA_WIDTH - 1.
APPEND_EOL, 1, when 1 send 8'h0A then 8'h0D after the digits; when 0 send digits only.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
value  input  DATA_WIDTH  unsigned sample to print
value_valid  input  1  sample present on value
value_ready  output  1  block can accept a sample this cycle
busy  output  1  conversion or transmission in progress
tx_start  output  1  one-cycle start pulse to uart_tx
tx_data  output  8  byte to uart_tx din
tx_done  input  1  one-cycle pulse from uart_tx when a byte has finished

Behaviour:
- Reset (sync, active-high): state=IDLE, value_ready=1, busy=0, tx_start=0, tx_data=8'h00, internal shift/BCD registers=0.
- value_ready=1 only in IDLE; busy = !value_ready. A sample is accepted on a clock edge where value_valid && value_ready. value_valid outside IDLE is ignored, not queued.
- States: IDLE -> CONVERT -> FIND_MSD -> LOAD -> WAIT -> (LOAD | IDLE).
- CONVERT: double-dabble, exactly DATA_WIDTH cycles. Each cycle: add 3 to every BCD nibble >= 5, then shift left one bit, with the value MSB entering BCD bit 0.
- FIND_MSD: one cycle. Set digit index to the most-significant nonzero nibble. If all nibbles are 0, the index selects nibble 0 so that "0" is printed.
- LOAD: one cycle. tx_data <= 8'h30 + nibble[idx], or the EOL byte in EOL phase, and tx_start <= 1. tx_start is high for exactly one cycle.
- WAIT: tx_start=0 and tx_data held stable.
  - On tx_done, advance: next lower digit, then LF, then CR (if APPEND_EOL), then IDLE.
  - Going to IDLE: tx_data <= 8'h00 and value_ready asserts on the cycle after the final tx_done.
- tx_done seen in IDLE, CONVERT, FIND_MSD or LOAD is ignored.
- No timeout: WAIT holds indefinitely until tx_done.
- Latency: accept edge -> tx_start high after DATA_WIDTH+2 cycles (18 for the default).
- Byte count per sample = significant digits + 2·APPEND_EOL. Range 3..7 for the defaults.
- Reset mid-operation: immediate return to reset values. A byte already started in uart_tx completes on the line; its tx_done arrives in IDLE and is ignored.
- Simultaneous value_valid and reset: reset wins, sample dropped.
- Arithmetic: BCD register is 4·NUM_DIGITS bits; nibble adjust is modulo-16-free because a nibble >= 5 plus 3 is at most 12. The ASCII add is 8-bit, producing 0x30..0x39 only.

Decomposition:
- Package uart_pkg:
  - ASCII_ZERO=8'h30, ASCII_LF=8'h0A, ASCII_CR=8'h0D.
  - enum logic [2:0] fmt_state_t {IDLE, CONVERT, FIND_MSD, LOAD, WAIT}.
- Sub-module bin2bcd_seq: start/done, DATA_WIDTH and NUM_DIGITS parameters, performs the CONVERT phase. The top FSM waits on its done pulse; the FIND_MSD and latency numbers above include its handshake.
- Top-level connections:
  - The top instantiates the formatter; uart_tx stays separate.
  - Formatter tx_start/tx_data/tx_done connect to uart_tx start/din/done.

Test Plan:
- value=1234, uart_tx model with tx_done 10 cycles after each tx_start -> bytes 31 32 33 34 0A 0D, exactly 6 tx_start pulses, value_ready returns 1 cycle after the last done.
- value=0 -> bytes 30 0A 0D. value=65535 -> 36 35 35 33 35 0A 0D. value=7, APPEND_EOL=0 -> single byte 37.
- Latency check: accept at cycle N -> tx_start at N+18. tx_data is constant from the tx_start cycle until the tx_done cycle.
- value_valid held high with 42 then 99 during busy -> only 42 printed. After idle, 99 is accepted on the first ready cycle, giving 34 32 0A 0D then 39 39 0A 0D.
- Spurious tx_done pulses in IDLE and during CONVERT -> no state change and no extra bytes.
- Reset asserted in WAIT on the second digit of 500 -> next cycle all outputs at reset values, the late tx_done is ignored, and a following value=8 prints 38 0A 0D cleanly.
